// File: rtl/proc_stat_calc_pkg.sv
// Shared constants, packed result layout and helpers for the per-channel
// statistics engine; the processing register map imports this for unpacking.
package proc_stat_pkg;

    localparam int C_INDX_WIDTH  = 10;
    localparam int C_DW_WIRE_MEM = 24;
    localparam int C_SMP_W       = C_DW_WIRE_MEM - C_INDX_WIDTH;
    localparam int C_SUM_W       = C_SMP_W + C_INDX_WIDTH;

    typedef struct packed {
        logic signed [C_SMP_W-1:0]      value;
        logic        [C_INDX_WIDTH-1:0] index;
    } t_mm_word;

    function automatic t_mm_word f_pack(input logic signed [C_SMP_W-1:0] value,
                                        input logic [C_INDX_WIDTH-1:0]   index);
        t_mm_word w;
        w.value = value;
        w.index = index;
        return w;
    endfunction

    function automatic int f_smp_w(input int dw_wire_mem, input int indx_width);
        return dw_wire_mem - indx_width;
    endfunction

    // A full frame of extreme samples needs indx_width extra bits of headroom.
    function automatic int f_sum_w(input int smp_w, input int indx_width);
        return smp_w + indx_width;
    endfunction

endpackage

// File: rtl/proc_minmax_trk.sv
// Running extreme (min or max) tracker with in-frame index; exposes the
// post-sample value so a frame-end snapshot can include the last sample.
module proc_minmax_trk #(
    parameter int G_SMP_W      = 14,
    parameter int G_INDX_WIDTH = 10,
    parameter bit G_IS_MAX     = 1'b0
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       smp_en,
    input  logic                       first,
    input  logic signed [G_SMP_W-1:0]  smp,
    input  logic [G_INDX_WIDTH-1:0]    idx,
    output logic signed [G_SMP_W-1:0]  nxt_val,
    output logic [G_INDX_WIDTH-1:0]    nxt_idx
);

    logic signed [G_SMP_W-1:0] ext_val_r;
    logic [G_INDX_WIDTH-1:0]   ext_idx_r;
    logic                      better_s;

    // Strict compare so ties keep the earliest index.
    always_comb begin
        better_s = 1'b0;
        nxt_val  = ext_val_r;
        nxt_idx  = ext_idx_r;
        if (G_IS_MAX) begin
            better_s = (smp > ext_val_r);
        end else begin
            better_s = (smp < ext_val_r);
        end
        if (smp_en && (first || better_s)) begin
            nxt_val = smp;
            nxt_idx = idx;
        end else begin
            nxt_val = ext_val_r;
            nxt_idx = ext_idx_r;
        end
    end

    // Running extreme register.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            ext_val_r <= {G_SMP_W{1'b0}};
            ext_idx_r <= {G_INDX_WIDTH{1'b0}};
        end else begin
            ext_val_r <= nxt_val;
            ext_idx_r <= nxt_idx;
        end
    end

endmodule

// File: rtl/proc_stat_calc.sv
// Frame statistics engine: per frame of 2^G_INDX_WIDTH samples it publishes
// min/max (with index) and floor average, with read-acknowledged valid flags.
module proc_stat_calc
    import proc_stat_pkg::*;
#(
    parameter int G_INDX_WIDTH  = 10,
    parameter int G_DW_WIRE_MEM = 24,
    parameter int G_BIT_WIDTH   = 32,
    localparam int G_SMP_W      = f_smp_w(G_DW_WIRE_MEM, G_INDX_WIDTH)
) (
    input  logic                      i_clk,
    input  logic                      i_aresetn,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [G_SMP_W-1:0]        s_axis_tdata,
    input  logic                      i_restart,
    input  logic                      i_rd_min,
    input  logic                      i_rd_max,
    input  logic                      i_rd_avg,
    output logic [G_DW_WIRE_MEM-1:0]  o_mem_data_min,
    output logic [G_DW_WIRE_MEM-1:0]  o_mem_data_max,
    output logic [G_BIT_WIDTH-1:0]    o_mem_data_avg,
    output logic                      o_vld_min,
    output logic                      o_vld_max,
    output logic                      o_vld_avg,
    output logic                      o_ovf
);

    localparam int C_SUM = f_sum_w(G_SMP_W, G_INDX_WIDTH);

    logic                         tready_r;
    logic [G_INDX_WIDTH-1:0]      q_idx;
    logic signed [C_SUM-1:0]      sum_r;
    logic signed [C_SUM-1:0]      sum_nxt_s;
    logic signed [C_SUM-1:0]      sum_shr_s;
    logic signed [G_BIT_WIDTH-1:0] avg_nxt_s;
    logic signed [G_SMP_W-1:0]    smp_s;
    logic                         accept_s;
    logic                         first_s;
    logic                         frame_end_s;
    logic                         ovf_hit_s;
    logic signed [G_SMP_W-1:0]    min_val_s;
    logic signed [G_SMP_W-1:0]    max_val_s;
    logic [G_INDX_WIDTH-1:0]      min_idx_s;
    logic [G_INDX_WIDTH-1:0]      max_idx_s;

    assign s_axis_tready = tready_r;
    assign smp_s         = s_axis_tdata;
    assign accept_s      = s_axis_tvalid & tready_r & ~i_restart;
    assign first_s       = (q_idx == {G_INDX_WIDTH{1'b0}});
    assign frame_end_s   = accept_s & (q_idx == {G_INDX_WIDTH{1'b1}});

    proc_minmax_trk #(
        .G_SMP_W(G_SMP_W), .G_INDX_WIDTH(G_INDX_WIDTH), .G_IS_MAX(1'b0)
    ) u_min (
        .clk(i_clk), .aresetn(i_aresetn), .smp_en(accept_s), .first(first_s),
        .smp(smp_s), .idx(q_idx), .nxt_val(min_val_s), .nxt_idx(min_idx_s)
    );

    proc_minmax_trk #(
        .G_SMP_W(G_SMP_W), .G_INDX_WIDTH(G_INDX_WIDTH), .G_IS_MAX(1'b1)
    ) u_max (
        .clk(i_clk), .aresetn(i_aresetn), .smp_en(accept_s), .first(first_s),
        .smp(smp_s), .idx(q_idx), .nxt_val(max_val_s), .nxt_idx(max_idx_s)
    );

    // Accumulate and derive the floor average of the frame including this sample.
    always_comb begin
        sum_nxt_s = sum_r;
        if (accept_s) begin
            if (first_s) begin
                sum_nxt_s = C_SUM'(smp_s);
            end else begin
                sum_nxt_s = sum_r + C_SUM'(smp_s);
            end
        end else begin
            sum_nxt_s = sum_r;
        end
        sum_shr_s = sum_nxt_s >>> G_INDX_WIDTH;
        avg_nxt_s = G_BIT_WIDTH'($signed(sum_shr_s[G_SMP_W-1:0]));
        ovf_hit_s = (o_vld_min & ~i_rd_min) | (o_vld_max & ~i_rd_max) |
                    (o_vld_avg & ~i_rd_avg);
    end

    // Stream side: ready, index counter and accumulator.
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            tready_r <= 1'b0;
            q_idx    <= {G_INDX_WIDTH{1'b0}};
            sum_r    <= {C_SUM{1'b0}};
        end else begin
            tready_r <= 1'b1;
            sum_r    <= sum_nxt_s;
            if (i_restart) begin
                q_idx <= {G_INDX_WIDTH{1'b0}};
            end else if (accept_s) begin
                q_idx <= q_idx + {{(G_INDX_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                q_idx <= q_idx;
            end
        end
    end

    // Result side: snapshots, valid flags and sticky overflow; a frame end
    // wins over a coincident read strobe.
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            o_mem_data_min <= {G_DW_WIRE_MEM{1'b0}};
            o_mem_data_max <= {G_DW_WIRE_MEM{1'b0}};
            o_mem_data_avg <= {G_BIT_WIDTH{1'b0}};
            o_vld_min      <= 1'b0;
            o_vld_max      <= 1'b0;
            o_vld_avg      <= 1'b0;
            o_ovf          <= 1'b0;
        end else if (frame_end_s) begin
            o_mem_data_min <= {min_val_s, min_idx_s};
            o_mem_data_max <= {max_val_s, max_idx_s};
            o_mem_data_avg <= avg_nxt_s;
            o_vld_min      <= 1'b1;
            o_vld_max      <= 1'b1;
            o_vld_avg      <= 1'b1;
            o_ovf          <= o_ovf | ovf_hit_s;
        end else begin
            o_vld_min <= o_vld_min & ~i_rd_min;
            o_vld_max <= o_vld_max & ~i_rd_max;
            o_vld_avg <= o_vld_avg & ~i_rd_avg;
            o_ovf     <= o_ovf;
        end
    end

endmodule

// File: tb/tb_proc_stat_calc.sv
// Self-checking bench for proc_stat_calc with 4-sample frames: directed
// scenarios followed by a random stream, all checked against a frame model.
module tb_proc_stat_calc;

    localparam int IW = 2;
    localparam int DW = 16;
    localparam int BW = 32;
    localparam int SW = DW - IW;
    localparam int N  = 1 << IW;

    logic          i_clk = 1'b0;
    logic          i_aresetn = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [SW-1:0] s_axis_tdata = '0;
    logic          i_restart = 1'b0;
    logic          i_rd_min = 1'b0, i_rd_max = 1'b0, i_rd_avg = 1'b0;
    logic [DW-1:0] o_mem_data_min, o_mem_data_max;
    logic [BW-1:0] o_mem_data_avg;
    logic          o_vld_min, o_vld_max, o_vld_avg, o_ovf;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int            frame_q[$];
    logic          e_tready = 1'b0;
    logic [DW-1:0] e_min = '0, e_max = '0;
    logic [BW-1:0] e_avg = '0;
    logic          e_vmin = 1'b0, e_vmax = 1'b0, e_vavg = 1'b0, e_ovf = 1'b0;

    proc_stat_calc #(.G_INDX_WIDTH(IW), .G_DW_WIRE_MEM(DW), .G_BIT_WIDTH(BW)) dut (
        .i_clk(i_clk), .i_aresetn(i_aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .i_restart(i_restart),
        .i_rd_min(i_rd_min), .i_rd_max(i_rd_max), .i_rd_avg(i_rd_avg),
        .o_mem_data_min(o_mem_data_min), .o_mem_data_max(o_mem_data_max),
        .o_mem_data_avg(o_mem_data_avg),
        .o_vld_min(o_vld_min), .o_vld_max(o_vld_max), .o_vld_avg(o_vld_avg),
        .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tready", BW'(s_axis_tready), BW'(e_tready));
        chk("min", BW'(o_mem_data_min), BW'(e_min));
        chk("max", BW'(o_mem_data_max), BW'(e_max));
        chk("avg", o_mem_data_avg, e_avg);
        chk("vld_min", BW'(o_vld_min), BW'(e_vmin));
        chk("vld_max", BW'(o_vld_max), BW'(e_vmax));
        chk("vld_avg", BW'(o_vld_avg), BW'(e_vavg));
        chk("ovf", BW'(o_ovf), BW'(e_ovf));
    endtask

    // Frame results straight from the sample list: first extreme wins, floor average.
    task automatic finish_frame();
        int mn, mx, mni, mxi, sum, avg;
        logic [SW-1:0] v;
        mn = frame_q[0]; mx = frame_q[0]; mni = 0; mxi = 0; sum = 0;
        for (int i = 0; i < N; i++) begin
            sum += frame_q[i];
            if (frame_q[i] < mn) begin mn = frame_q[i]; mni = i; end
            if (frame_q[i] > mx) begin mx = frame_q[i]; mxi = i; end
        end
        avg = (sum >= 0) ? sum / N : -((-sum + N - 1) / N);
        v = SW'(mn); e_min = {v, IW'(mni)};
        v = SW'(mx); e_max = {v, IW'(mxi)};
        e_avg = BW'(avg);
        frame_q.delete();
    endtask

    task automatic cyc(input logic rst_n, input logic v, input int d, input logic rs,
                       input logic rdm, input logic rdx, input logic rda);
        logic acc, fe;
        i_aresetn = rst_n; s_axis_tvalid = v; s_axis_tdata = SW'(d);
        i_restart = rs; i_rd_min = rdm; i_rd_max = rdx; i_rd_avg = rda;
        @(posedge i_clk);
        if (!rst_n) begin
            frame_q.delete();
            e_tready = 1'b0; e_min = '0; e_max = '0; e_avg = '0;
            e_vmin = 1'b0; e_vmax = 1'b0; e_vavg = 1'b0; e_ovf = 1'b0;
        end else begin
            acc = v && e_tready && !rs;
            fe  = 1'b0;
            if (rs) frame_q.delete();
            else if (acc) begin
                frame_q.push_back(d);
                fe = (frame_q.size() == N);
            end
            if (fe) begin
                if ((e_vmin && !rdm) || (e_vmax && !rdx) || (e_vavg && !rda)) e_ovf = 1'b1;
                e_vmin = 1'b1; e_vmax = 1'b1; e_vavg = 1'b1;
                finish_frame();
            end else begin
                if (rdm) e_vmin = 1'b0;
                if (rdx) e_vmax = 1'b0;
                if (rda) e_vavg = 1'b0;
            end
            e_tready = 1'b1;
        end
        #1;
        check_all();
    endtask

    task automatic smp(input int d);
        cyc(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int d;
        // reset
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        // frame 1
        smp(5); smp(-3); smp(7); smp(-3);
        chk("f1_min_const", BW'(o_mem_data_min), BW'({14'h3FFD, 2'd1}));
        chk("f1_max_const", BW'(o_mem_data_max), BW'({14'd7, 2'd2}));
        chk("f1_avg_const", o_mem_data_avg, 32'd1);
        // frame 2, frame 1 unread
        smp(-1); smp(-1); smp(-1); smp(-2);
        chk("f2_avg_const", o_mem_data_avg, 32'hFFFF_FFFE);
        chk("f2_min_const", BW'(o_mem_data_min), BW'({14'h3FFE, 2'd3}));
        chk("f2_max_const", BW'(o_mem_data_max), BW'({14'h3FFF, 2'd0}));
        chk("f2_ovf_const", BW'(o_ovf), 32'd1);
        // read min, then strobe coincident with frame end
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        smp(10); smp(20); smp(30);
        cyc(1'b1, 1'b1, 40, 1'b0, 1'b1, 1'b0, 1'b0);
        // fresh reset, read all, then all strobes on the frame end: no overflow
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        smp(1); smp(1); smp(1); smp(1);
        smp(-8); smp(3); smp(3);
        cyc(1'b1, 1'b1, -8, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("coinc_ovf_const", BW'(o_ovf), 32'd0);
        // gapped stream
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        smp(5); idle(); smp(-3); idle(); smp(7); idle(); smp(-3);
        // restart after 2 samples
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        smp(100); smp(-100);
        cyc(1'b1, 1'b1, 55, 1'b1, 1'b0, 1'b0, 1'b0);
        smp(1); smp(2); smp(3); smp(4);
        chk("rst_avg_const", o_mem_data_avg, 32'd2);
        chk("rst_max_const", BW'(o_mem_data_max), BW'({14'd4, 2'd3}));
        // reset mid-frame with results pending, then a clean frame
        smp(9); smp(9);
        cyc(1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        smp(-20); smp(6); smp(-20); smp(0);
        // random stream
        for (int i = 0; i < 600; i++) begin
            d = int'($urandom_range(0, 16383)) - 8192;
            if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 1) ? 8191 : -8192;
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), d,
                ($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
